// File: rtl/rr_arbiter_4.sv
//==============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with done/hold-limit release
//               and a mandatory one-cycle gap between owners.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       any_req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       r_gnt_id;
    logic [1:0]       w_gnt_id_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;

    logic [7:0]       w_req_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_win_off;
    logic [1:0]       w_win_id;
    logic             w_win_valid;
    logic [3:0]       w_win_onehot;
    logic             w_rel_req;
    logic             w_rel_done;
    logic             w_rel_max;

    assign any_req = |req;

    // Rotate so bit 0 is the requester just after the last owner; the lowest
    // set bit of the rotated vector is then the round-robin winner.
    assign w_req_dbl = {req, req};
    assign w_rot     = w_req_dbl[(3'(r_ptr) + 3'd1) +: 4];

    always_comb begin
        w_win_off = 2'd0;
        casez (w_rot)
            4'b???1: w_win_off = 2'd0;
            4'b??10: w_win_off = 2'd1;
            4'b?100: w_win_off = 2'd2;
            4'b1000: w_win_off = 2'd3;
            default: w_win_off = 2'd0;
        endcase
    end

    assign w_win_valid  = |w_rot;
    assign w_win_id     = r_ptr + 2'd1 + w_win_off;
    assign w_win_onehot = 4'b0001 << w_win_id;

    assign w_rel_req  = ~req[r_gnt_id];
    assign w_rel_done = done;
    assign w_rel_max  = (r_hold_cnt == c_max_hold);

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_busy_nxt     = r_busy;
        w_timeout_nxt  = 1'b0;
        w_hold_cnt_nxt = r_hold_cnt;

        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_win_valid) begin
                    w_state_nxt    = ST_GRANT;
                    w_gnt_nxt      = w_win_onehot;
                    w_gnt_id_nxt   = w_win_id;
                    w_busy_nxt     = 1'b1;
                    w_hold_cnt_nxt = c_cnt_one;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_gnt_nxt      = 4'b0000;
                    w_gnt_id_nxt   = 2'd0;
                    w_busy_nxt     = 1'b0;
                    w_hold_cnt_nxt = '0;
                end
            end

            ST_GRANT: begin
                if (w_rel_req || w_rel_done || w_rel_max) begin
                    w_state_nxt    = ST_GAP;
                    w_gnt_nxt      = 4'b0000;
                    w_gnt_id_nxt   = 2'd0;
                    w_busy_nxt     = 1'b0;
                    w_ptr_nxt      = r_gnt_id;
                    w_hold_cnt_nxt = '0;
                    // Only a pure hold-limit release counts as a forced release
                    w_timeout_nxt  = w_rel_max && !w_rel_req && !w_rel_done;
                end else if (r_hold_cnt != c_max_hold) begin
                    w_hold_cnt_nxt = r_hold_cnt + c_cnt_one;
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_gnt_nxt      = 4'b0000;
                w_gnt_id_nxt   = 2'd0;
                w_busy_nxt     = 1'b0;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd3;
            r_gnt      <= 4'b0000;
            r_gnt_id   <= 2'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
//==============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed vector bench for rr_arbiter_4 (MAX_HOLD = 8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    wire        any_req;
    wire  [3:0] gnt;
    wire  [1:0] gnt_id;
    wire        busy;
    wire        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_4 #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .any_req (any_req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] r, input logic d,
                                input logic [3:0] g, input logic [1:0] id,
                                input logic b, input logic t);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.gnt  = g;
        v.id   = id;
        v.busy = b;
        v.to   = t;
        tbl.push_back(v);
    endfunction

    // Packed as {any_req, gnt, gnt_id, busy, timeout}
    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {any_req, gnt, gnt_id, busy, timeout};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {any,gnt,id,busy,to}=%b required %b", name, act, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // Directed vectors: inputs sampled at the edge, outputs seen after it.
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);  // idle
        add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);  // first grant goes to 0
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);  // owner drops req -> gap
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);  // idle
        // all requesting, done on 3rd cycle of each grant; ptr=0 now
        add(4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b1111, 0, 4'b0010, 2'd1, 1, 0);  // wraps back to 1
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        // owner 1 holds, no preemption; then 3 wins over 1, then 0 over 1
        add(4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        add(4'b1010, 0, 4'b0010, 2'd1, 1, 0);
        add(4'b1000, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b1000, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1011, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1011, 1, 4'b0000, 2'd0, 0, 0);
        add(4'b1011, 0, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 1, 4'b0000, 2'd0, 0, 0);  // done + req drop together
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        // hold limit: 8 grant cycles, forced release, regrant
        for (int i = 0; i < 8; i++) add(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0100, 0, 4'b0000, 2'd0, 0, 1);
        add(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        // req drop exactly at the hold limit is not a timeout
        for (int i = 0; i < 8; i++) add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        repeat (2) @(posedge clk);
        #1 check("reset_state", 9'b0_0000_00_0_0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            req  = tbl[i].req;
            done = tbl[i].done;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i),
                     {|tbl[i].req, tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].to});
        end

        // any_req follows req without a clock edge
        @(negedge clk) req = 4'b0110;
        #1 check("any_req_comb", 9'b1_0000_00_0_0);
        req = 4'b0000;
        #1 check("any_req_comb_low", 9'b0_0000_00_0_0);

        // asynchronous reset in the middle of a grant (ptr=0 here)
        @(negedge clk) req = 4'b0010;
        @(posedge clk);
        #1 check("grant_before_reset", 9'b1_0010_01_1_0);
        #2 rst = 1'b1;
        #1 check("async_reset", 9'b1_0000_00_0_0);
        @(negedge clk) req = 4'b1111;
        @(posedge clk);
        #1 check("reset_held", 9'b1_0000_00_0_0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("first_after_reset", 9'b1_0001_00_1_0);

        // done with owner's req dropping in the same cycle: one release, ptr=0
        @(negedge clk);
        req  = 4'b1110;
        done = 1'b1;
        @(posedge clk);
        #1 check("dual_release", 9'b1_0000_00_0_0);
        @(negedge clk) done = 1'b0;
        @(posedge clk);
        #1 check("ptr_after_dual", 9'b1_0010_01_1_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
